// File: rtl/dyn_mux_arbiter.sv
// Wormhole round-robin arbiter for one 8:1 output mux of the dynamic node crossbar.
// Locks the mux select for a whole packet and issues per-flit pop pulses to the winner.
//
// state    | meaning
// ---------+------------------------------------------------------------
// ST_IDLE  | no packet locked; arbitrate among requesters every cycle
// ST_ROUTE | packet locked on r_sel; count down remaining flits
module dyn_mux_arbiter #(
   parameter int LEN_WIDTH = 8
) (
   input  logic                   clk,
   input  logic                   rst_n,
   input  logic [7:0]             req_i,
   input  logic [8*LEN_WIDTH-1:0] head_len_i,
   input  logic                   out_ready_i,
   output logic [2:0]             sel_o,
   output logic                   out_valid_o,
   output logic [7:0]             grant_o,
   output logic                   busy_o
);

   typedef enum logic {
      ST_IDLE  = 1'b0,
      ST_ROUTE = 1'b1
   } state_t;

   state_t               r_state;
   state_t               w_state_nxt;
   logic [2:0]           r_sel;
   logic [2:0]           w_sel_nxt;
   logic [2:0]           r_ptr;
   logic [2:0]           w_ptr_nxt;
   logic [LEN_WIDTH:0]   r_remain;
   logic [LEN_WIDTH:0]   w_remain_nxt;
   logic [LEN_WIDTH-1:0] w_len [8];
   logic [2:0]           w_win;
   logic [2:0]           w_idx;
   logic                 w_found;
   logic                 w_valid;
   logic                 w_xfer;

   always_comb begin
      for (int i = 0; i < 8; i++) begin
         w_len[i] = head_len_i[i*LEN_WIDTH +: LEN_WIDTH];
      end
   end

   // Circular search starting just after the last winner; the last winner itself is checked last.
   always_comb begin
      w_win   = '0;
      w_found = 1'b0;
      w_idx   = '0;
      for (int k = 1; k <= 8; k++) begin
         w_idx = r_ptr + 3'(k);
         if (!w_found && req_i[w_idx]) begin
            w_win   = w_idx;
            w_found = 1'b1;
         end
      end
   end

   always_comb begin
      w_state_nxt  = r_state;
      w_sel_nxt    = r_sel;
      w_ptr_nxt    = r_ptr;
      w_remain_nxt = r_remain;
      w_valid      = 1'b0;
      w_xfer       = 1'b0;
      grant_o      = '0;
      case (r_state)
         ST_IDLE: begin
            if (w_found) begin
               w_state_nxt  = ST_ROUTE;
               w_sel_nxt    = w_win;
               w_remain_nxt = {1'b0, w_len[w_win]} + (LEN_WIDTH+1)'(1);
            end
         end
         ST_ROUTE: begin
            // A dropped request is a bubble: the lock and count are held.
            w_valid = req_i[r_sel];
            w_xfer  = w_valid & out_ready_i;
            if (w_xfer) begin
               grant_o[r_sel] = 1'b1;
               w_remain_nxt   = r_remain - (LEN_WIDTH+1)'(1);
               if (r_remain == (LEN_WIDTH+1)'(1)) begin
                  w_state_nxt = ST_IDLE;
                  w_ptr_nxt   = r_sel;
               end
            end
         end
         default: begin
            w_state_nxt = ST_IDLE;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_state  <= ST_IDLE;
         r_sel    <= '0;
         r_ptr    <= 3'd7;
         r_remain <= '0;
      end else begin
         r_state  <= w_state_nxt;
         r_sel    <= w_sel_nxt;
         r_ptr    <= w_ptr_nxt;
         r_remain <= w_remain_nxt;
      end
   end

   assign sel_o       = r_sel;
   assign out_valid_o = w_valid;
   assign busy_o      = (r_state == ST_ROUTE);

endmodule

// File: tb/tb_dyn_mux_arbiter.sv
// Scoreboard bench for dyn_mux_arbiter: a packet-level reference model predicts each cycle's
// outputs into a queue that an independent negedge monitor drains and compares.
module tb_dyn_mux_arbiter;
   localparam int LW = 8;

   logic            clk = 1'b0;
   logic            rst_n;
   logic [7:0]      req_i;
   logic [8*LW-1:0] head_len_i;
   logic            out_ready_i;
   logic [2:0]      sel_o;
   logic            out_valid_o;
   logic [7:0]      grant_o;
   logic            busy_o;

   dyn_mux_arbiter #(.LEN_WIDTH(LW)) dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .req_i       (req_i),
      .head_len_i  (head_len_i),
      .out_ready_i (out_ready_i),
      .sel_o       (sel_o),
      .out_valid_o (out_valid_o),
      .grant_o     (grant_o),
      .busy_o      (busy_o)
   );

   always #5 clk = ~clk;

   typedef struct packed {
      logic [7:0] grant;
      logic [2:0] sel;
      logic       valid;
      logic       busy;
   } exp_t;

   exp_t exp_q[$];
   int   obs_idx[$];
   int   obs_cyc[$];
   int   checks   = 0;
   int   failures = 0;
   int   cyc      = 0;

   // Reference model: which input owns the output (-1 = none), flits still owed, last winner.
   int m_owner = -1;
   int m_left  = 0;
   int m_last  = 7;
   int m_sel   = 0;

   always @(posedge clk) cyc <= cyc + 1;

   always @(negedge clk) begin
      exp_t e;
      if (exp_q.size() > 0) begin
         e = exp_q.pop_front();
         checks++;
         if ({grant_o, sel_o, out_valid_o, busy_o} !== e) begin
            failures++;
            $display("FAIL cycle_outputs cyc=%0d got grant=%h sel=%0d valid=%b busy=%b want grant=%h sel=%0d valid=%b busy=%b",
                     cyc, grant_o, sel_o, out_valid_o, busy_o, e.grant, e.sel, e.valid, e.busy);
         end
      end
      for (int i = 0; i < 8; i++) begin
         if (grant_o[i]) begin
            obs_idx.push_back(i);
            obs_cyc.push_back(cyc);
         end
      end
   end

   task automatic chk(input string name, input int got, input int want);
      checks++;
      if (got !== want) begin
         failures++;
         $display("FAIL %s got=%0d want=%0d", name, got, want);
      end
   endtask

   function automatic logic [8*LW-1:0] len_of(input int idx, input int len);
      logic [8*LW-1:0] v;
      v = '0;
      v[idx*LW +: LW] = LW'(len);
      return v;
   endfunction

   task automatic step(input logic [7:0] req, input logic [8*LW-1:0] lens,
                       input logic rdy, input logic rst);
      exp_t e;
      int   w;
      @(posedge clk);
      #1;
      rst_n       = rst;
      req_i       = req;
      head_len_i  = lens;
      out_ready_i = rdy;
      e     = '0;
      e.sel = 3'(m_sel);
      if (m_owner >= 0) begin
         e.busy  = 1'b1;
         e.valid = req[m_owner];
         if (req[m_owner] && rdy) begin
            e.grant = 8'(1) << m_owner;
            m_left--;
         end
      end
      exp_q.push_back(e);
      w = 0;
      if (!rst) begin
         m_owner = -1;
         m_left  = 0;
         m_last  = 7;
         m_sel   = 0;
      end else if (m_owner < 0) begin
         if (req != 8'h00) begin
            for (int k = 1; k <= 8; k++) begin
               w = (m_last + k) % 8;
               if (req[w]) break;
            end
            m_owner = w;
            m_sel   = w;
            m_left  = int'(lens[w*LW +: LW]) + 1;
         end
      end else if (m_left == 0) begin
         m_last  = m_owner;
         m_owner = -1;
      end
   endtask

   // Finish any locked packet by keeping its owner requesting, then let the monitor catch up.
   task automatic drain();
      for (int n = 0; n < 600; n++) begin
         if (m_owner < 0) break;
         step(8'(1) << m_owner, '0, 1'b1, 1'b1);
      end
      chk("drain_idle", (m_owner < 0) ? 1 : 0, 1);
      step(8'h00, '0, 1'b1, 1'b1);
      @(negedge clk);
      #1;
   endtask

   task automatic clear_obs();
      obs_idx.delete();
      obs_cyc.delete();
   endtask

   initial begin
      logic [8*LW-1:0] lens;
      rst_n       = 1'b0;
      req_i       = 8'hFF;
      head_len_i  = '0;
      out_ready_i = 1'b1;
      @(posedge clk);

      // Reset with all inputs requesting, then round-robin over equal single-flit packets.
      step(8'hFF, '0, 1'b1, 1'b0);
      step(8'hFF, '0, 1'b1, 1'b0);
      clear_obs();
      for (int n = 0; n < 18; n++) step(8'hFF, '0, 1'b1, 1'b1);
      step(8'h00, '0, 1'b1, 1'b1);
      drain();
      chk("rr_count", obs_idx.size(), 9);
      if (obs_idx.size() == 9) begin
         for (int i = 0; i < 9; i++) chk("rr_winner", obs_idx[i], i % 8);
         for (int i = 1; i < 9; i++) chk("rr_gap", obs_cyc[i] - obs_cyc[i-1], 2);
      end

      // Single packet, three flits on input 3.
      clear_obs();
      for (int n = 0; n < 4; n++) step(8'h08, len_of(3, 2), 1'b1, 1'b1);
      drain();
      chk("single_count", obs_idx.size(), 3);
      if (obs_idx.size() == 3) begin
         for (int i = 0; i < 3; i++) chk("single_idx", obs_idx[i], 3);
         chk("single_span", obs_cyc[2] - obs_cyc[0], 2);
      end

      // Wormhole lock with a two-cycle bubble while input 2 keeps requesting.
      clear_obs();
      lens = len_of(5, 3);
      step(8'h24, lens, 1'b1, 1'b1);
      step(8'h24, lens, 1'b1, 1'b1);
      step(8'h24, lens, 1'b1, 1'b1);
      step(8'h04, lens, 1'b1, 1'b1);
      step(8'h04, lens, 1'b1, 1'b1);
      step(8'h24, lens, 1'b1, 1'b1);
      step(8'h24, lens, 1'b1, 1'b1);
      step(8'h04, lens, 1'b1, 1'b1);
      step(8'h04, lens, 1'b1, 1'b1);
      step(8'h00, lens, 1'b1, 1'b1);
      drain();
      chk("lock_count", obs_idx.size(), 5);
      if (obs_idx.size() == 5) begin
         for (int i = 0; i < 4; i++) chk("lock_idx5", obs_idx[i], 5);
         chk("lock_then2", obs_idx[4], 2);
      end

      // Backpressure: two flits, ready alternating.
      clear_obs();
      lens = len_of(1, 1);
      step(8'h02, lens, 1'b0, 1'b1);
      step(8'h02, lens, 1'b0, 1'b1);
      step(8'h02, lens, 1'b1, 1'b1);
      step(8'h02, lens, 1'b0, 1'b1);
      step(8'h02, lens, 1'b1, 1'b1);
      step(8'h00, lens, 1'b1, 1'b1);
      drain();
      chk("bp_count", obs_idx.size(), 2);
      if (obs_idx.size() == 2) chk("bp_gap", obs_cyc[1] - obs_cyc[0], 2);

      // Reset mid-packet, then the pointer must be back at 7 so input 0 beats input 7.
      clear_obs();
      lens = len_of(0, 10);
      for (int n = 0; n < 4; n++) step(8'h01, lens, 1'b1, 1'b1);
      step(8'h01, lens, 1'b1, 1'b0);
      step(8'h00, '0, 1'b1, 1'b1);
      chk("rst_mid_idle", busy_o, 0);
      clear_obs();
      step(8'h81, '0, 1'b1, 1'b1);
      step(8'h81, '0, 1'b1, 1'b1);
      step(8'h00, '0, 1'b1, 1'b1);
      drain();
      chk("rst_ptr_count", obs_idx.size(), 1);
      if (obs_idx.size() == 1) chk("rst_ptr_winner", obs_idx[0], 0);

      // Maximum length packet.
      clear_obs();
      lens = len_of(4, 255);
      for (int n = 0; n < 257; n++) step(8'h10, lens, 1'b1, 1'b1);
      step(8'h00, lens, 1'b1, 1'b1);
      drain();
      chk("maxlen_count", obs_idx.size(), 256);

      // Random traffic with occasional reset.
      for (int n = 0; n < 600; n++) begin
         for (int i = 0; i < 8; i++) lens[i*LW +: LW] = LW'($urandom_range(0, 4));
         step(8'($urandom), lens, ($urandom_range(0, 3) != 0) ? 1'b1 : 1'b0,
              ($urandom_range(0, 99) != 0) ? 1'b1 : 1'b0);
      end
      drain();
      chk("queue_empty", exp_q.size(), 0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/dyn_mux_arbiter.md
# dyn_mux_arbiter

Wormhole round-robin arbiter and sequencer for one 8:1 output mux of the dynamic node crossbar. It selects one of eight input requesters and drives the mux select. It holds that selection for the whole packet, using the payload-length field of the header flit. It issues per-flit grant (pop) pulses back to the winning input. One instance sits beside each output port's mux.

## Interface
Parameters:
- `LEN_WIDTH`, default 8: width of the header payload-length field, counted in flits after the header.

Ports:
- `clk`, input, 1: clock. One clock; all logic is rising-edge.
- `rst_n`, input, 1: reset. Synchronous and active-low.
- `req_i`, input, 8: bit i is high when input i has a flit at its head destined for this output.
- `head_len_i`, input, 8*LEN_WIDTH: slice i (`[i*LEN_WIDTH +: LEN_WIDTH]`) is the payload length of input i's head flit. It is only meaningful while that flit is a header.
- `out_ready_i`, input, 1: downstream can accept a flit this cycle.
- `sel_o`, output, 3: mux select, driven to the crossbar mux.
- `out_valid_o`, output, 1: the muxed flit is valid this cycle.
- `grant_o`, output, 8: one-hot pop. Bit `sel_o` is high in a cycle when a flit transfers.
- `busy_o`, output, 1: a packet is locked in (state ROUTE).

## Operation
- State machine has two states: IDLE and ROUTE.
- Registered state:
  - `state`
  - `sel_o`
  - `ptr` (3b, last winner)
  - `remain` (LEN_WIDTH+1 bits)
- Reset values, with `rst_n` low at a clock edge:
  - state = IDLE, `sel_o` = 0, `ptr` = 7, `remain` = 0.
  - Combinational outputs are therefore `out_valid_o` = 0, `grant_o` = 0, `busy_o` = 0.
- IDLE:
  - If `req_i` == 0, stay in IDLE.
  - Otherwise choose the winner w as the first set bit of `req_i`, searching circularly from `ptr`+1 (mod 8).
  - Next cycle: `sel_o` = w, `remain` = `head_len_i[w]` + 1 (total flits including header), state = ROUTE.
- ROUTE:
  - `out_valid_o` = `req_i[sel_o]`.
  - A transfer occurs when `xfer` = `out_valid_o & out_ready_i`.
  - `grant_o` = `xfer` ? (1 << `sel_o`) : 0.
  - On `xfer`, `remain` decrements.
  - If `xfer` occurs while `remain` == 1: state goes to IDLE, `ptr` = `sel_o`, and `sel_o` holds its value.
- Wormhole lock:
  - While in ROUTE, inputs other than `sel_o` are never granted, whatever `req_i` shows.
  - If `req_i[sel_o]` drops mid-packet (bubble), `out_valid_o` = 0 and the lock is held. `remain` is unchanged.
- `busy_o` = (state == ROUTE).
- In IDLE, `out_valid_o` and `grant_o` are 0 and `sel_o` holds its last value.
- Arithmetic: `remain` is LEN_WIDTH+1 bits, so length 2^LEN_WIDTH−1 gives 2^LEN_WIDTH flits with no overflow. Length 0 gives a single-flit packet.
- Reset asserted mid-packet discards the packet state: the block returns to IDLE with `ptr` = 7. Inputs are responsible for their own flush.
- Simultaneous requests are resolved solely by the round-robin order. There is no fixed priority beyond the reset state of `ptr`.

## Timing
- Arbitration latency is 1 cycle. If a request is present in IDLE at edge N, then `sel_o`, `busy_o` and `out_valid_o` are valid after edge N; the earliest grant is in cycle N+1.
- Throughput is one flit per cycle while `req_i[sel_o]` and `out_ready_i` are both high.
- Between packets there is exactly one idle cycle: the last transfer is in cycle M, IDLE is in M+1, and the next packet's first grant is in M+2 at the earliest.
- `grant_o` and `out_valid_o` are combinational from the registered state and `req_i`/`out_ready_i`. There is no combinational path from `head_len_i` to any output.
- `head_len_i` is sampled only on the IDLE→ROUTE edge.

## Test plan
- **Reset:** hold `rst_n`=0 for 2 cycles with `req_i`=8'hFF.
  - Required: `sel_o`=0, `out_valid_o`=0, `grant_o`=0, `busy_o`=0.
  - After release, the first winner is input 0.
- **Single packet:** `req_i`=8'h08, len[3]=2, `out_ready_i`=1.
  - Required: `sel_o`=3 from cycle 1.
  - `grant_o`=8'h08 for exactly 3 consecutive cycles, then `busy_o`=0.
- **Round-robin:** `req_i`=8'hFF held, every len=0.
  - Required: winners in order 0,1,2,…,7,0, each grant separated by 1 idle cycle.
- **Wormhole lock and bubble:** winner 5 with len=3.
  - Deassert `req_i[5]` for 2 cycles mid-packet while `req_i[2]`=1.
  - Required: `out_valid_o`=0 and `grant_o`=0 during the bubble, and `sel_o` stays 5.
  - 4 total grants go to input 5 before input 2 is granted.
- **Backpressure:** len=1, `out_ready_i` toggles 0,1,0,1.
  - Required: grants only in ready cycles, 2 grants in total, `remain` never underflows.
- **Reset mid-packet and max length:**
  - Assert `rst_n`=0 during a len=10 packet. Required: IDLE next cycle with `ptr`=7.
  - Separately, run len=255. Required: exactly 256 grants.
